// File: rtl/call_stack_pkg.sv
// Shared types for the return-address stack.
// Op decode built from the {push,pop} strobes.
package call_stack_pkg;

    typedef enum logic [1:0] {
        SOP_NONE    = 2'b00,
        SOP_POP     = 2'b01,
        SOP_PUSH    = 2'b10,
        SOP_REPLACE = 2'b11
    } stack_op_t;

    function automatic stack_op_t to_op(
        input logic push,
        input logic pop
    );
        return stack_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/lifo_regfile.sv
// Return-address storage for call_stack.
// One synchronous write port, one asynchronous read port.
module lifo_regfile #(
    parameter int A_WIDTH = 8,
    parameter int DEPTH   = 8,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IW-1:0]      waddr,
    input  logic [A_WIDTH-1:0] wdata,
    input  logic [IW-1:0]      raddr,
    output logic [A_WIDTH-1:0] rdata
);

    logic [A_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address LIFO feeding the PC on CALL/RET.
// Holds level, sticky error flags and the op decode.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int DEPTH   = 8,
    localparam int LW     = $clog2(DEPTH) + 1,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [A_WIDTH-1:0] pc_addr,
    output logic [A_WIDTH-1:0] ret_addr,
    output logic               empty,
    output logic               full,
    output logic [LW-1:0]      level,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    stack_op_t          op;
    logic [IW-1:0]      top_idx;
    logic [IW-1:0]      wr_idx;
    logic [A_WIDTH-1:0] wr_data;
    logic [A_WIDTH-1:0] rd_data;
    logic               wr_en;

    assign op      = to_op(push, pop);
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign top_idx = IW'(level - LW'(1));
    assign wr_data = pc_addr + A_WIDTH'(1);

    // Replace overwrites the top; plain push (or replace on empty) appends.
    assign wr_idx = (op == SOP_REPLACE && !empty) ? top_idx : IW'(level);

    always_comb begin
        wr_en = 1'b0;
        if (!rst) begin
            unique case (op)
                SOP_PUSH:    wr_en = !full;
                SOP_REPLACE: wr_en = 1'b1;
                SOP_POP:     wr_en = 1'b0;
                SOP_NONE:    wr_en = 1'b0;
            endcase
        end
    end

    assign ret_addr = empty ? '0 : rd_data;

    lifo_regfile #(
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_regs (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (wr_data),
        .raddr (top_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (op)
                SOP_PUSH: begin
                    if (full) overflow <= 1'b1;
                    else      level    <= level + LW'(1);
                end
                SOP_POP: begin
                    if (empty) underflow <= 1'b1;
                    else       level     <= level - LW'(1);
                end
                SOP_REPLACE: begin
                    if (empty) begin
                        level     <= LW'(1);
                        underflow <= 1'b1;
                    end
                end
                SOP_NONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed steps then random ops
// against a queue-based return-stack model.
module tb_call_stack;

    localparam int AW = 8;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] pc_addr = '0;
    logic [AW-1:0] ret_addr;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    call_stack #(
        .A_WIDTH (AW),
        .DEPTH   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .pc_addr   (pc_addr),
        .ret_addr  (ret_addr),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_top();
        return (q.size() == 0) ? '0 : q[q.size()-1];
    endfunction

    task automatic model(
        input logic          r,
        input logic          pu,
        input logic          po,
        input logic [AW-1:0] pc
    );
        logic [AW-1:0] v;
        v = pc + 8'd1;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (pu && po) begin
            if (q.size() == 0) begin
                q.push_back(v);
                m_udf = 1'b1;
            end else begin
                q[q.size()-1] = v;
            end
        end else if (pu) begin
            if (q.size() == D) m_ovf = 1'b1;
            else               q.push_back(v);
        end else if (po) begin
            if (q.size() == 0) m_udf = 1'b1;
            else               void'(q.pop_back());
        end
    endtask

    task automatic step(
        input logic          r,
        input logic          pu,
        input logic          po,
        input logic [AW-1:0] pc
    );
        @(negedge clk);
        rst = r;
        push = pu;
        pop = po;
        pc_addr = pc;
        #1;
        if (!r) chk("ret_same_cycle", ret_addr, m_top());
        @(posedge clk);
        model(r, pu, po, pc);
        #1;
        chk("level", level, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == D);
        chk("ret_addr", ret_addr, m_top());
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
    endtask

    initial begin
        // 1: reset beats a simultaneous push
        step(1, 1, 0, 8'h00);
        chk("t1_level", level, 0);
        chk("t1_ret", ret_addr, 0);
        step(0, 0, 0, 8'h00);

        // 2: two pushes then a pop
        step(0, 1, 0, 8'h10);
        step(0, 1, 0, 8'h20);
        chk("t2_ret", ret_addr, 8'h21);
        step(0, 0, 1, 8'h00);
        chk("t2_ret_after_pop", ret_addr, 8'h11);

        // 3: fill then overflow
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, AW'(i));
        chk("t3_full", full, 1);
        chk("t3_ret", ret_addr, 8'h08);
        step(0, 1, 0, 8'h40);
        chk("t3_ovf", overflow, 1);
        chk("t3_ret_hold", ret_addr, 8'h08);

        // 4: underflow and replace on empty
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("t4_udf", underflow, 1);
        step(0, 1, 1, 8'h05);
        chk("t4_ret", ret_addr, 8'h06);
        chk("t4_level", level, 1);

        // 5: replace with carry, then address wrap
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h10);
        step(0, 1, 0, 8'h20);
        step(0, 1, 0, 8'h30);
        step(0, 1, 1, 8'h7F);
        chk("t5_ret", ret_addr, 8'h80);
        step(0, 1, 0, 8'hFF);
        chk("t5_wrap", ret_addr, 8'h00);

        // 6: reset with pop while overflowed at level 4
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, 0, AW'(8'h50 + i));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
        chk("t6_pre_level", level, 4);
        step(1, 0, 1, 8'h00);
        chk("t6_ovf", overflow, 0);
        chk("t6_empty", empty, 1);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0,
                 AW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
